// File: rtl/width_change_pkg.sv
// Shared types and constants for the width_change_arbiter slice.
// Imported by the interface, the round-robin sub-module and the top.
package width_change_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HI   = 1'b1
  } state_e;

  localparam logic [7:0] PAD_DEFAULT = 8'h00;

  // Source index width, never narrower than one bit.
  function automatic int src_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/width_change_arbiter_if.sv
// Requester-side byte streams and converter-side byte/pair status bundled together.
// The arbiter uses the slave modport; the environment drives through master.
interface width_change_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int AWIDTH = 8
) ();
  import width_change_pkg::*;

  localparam int SRCW = src_width(NREQ);

  logic [NREQ-1:0]        req_vld;
  logic [NREQ*AWIDTH-1:0] req_data;
  logic [NREQ-1:0]        req_rdy;
  logic                   a_vld;
  logic [AWIDTH-1:0]      a;
  logic [SRCW-1:0]        pair_src;
  logic                   pair_done;
  logic                   pair_pad;
  logic                   busy;

  modport slave (
    input  req_vld, req_data,
    output req_rdy, a_vld, a, pair_src, pair_done, pair_pad, busy
  );

  modport master (
    output req_vld, req_data,
    input  req_rdy, a_vld, a, pair_src, pair_done, pair_pad, busy
  );

endinterface

// File: rtl/width_change_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// returned both one-hot and encoded.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int SRCW = width_change_pkg::src_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [SRCW-1:0] ptr,
  output logic [NREQ-1:0] gnt_oh,
  output logic [SRCW-1:0] gnt_idx,
  output logic            gnt_vld
);

  logic [SRCW-1:0] cand;

  // Scanning from the farthest candidate back to ptr lets the closest one overwrite.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = SRCW'((int'(ptr) + k) % NREQ);
      if (req[cand]) begin
        gnt_idx = cand;
        gnt_vld = 1'b1;
      end
    end
    if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/width_change_arbiter.sv
// Round-robin share of one 8-to-16 converter: each grant lasts exactly one byte pair,
// with a PAD byte closing a half-pair whose second byte never comes.
module width_change_arbiter
  import width_change_pkg::*;
#(
  parameter int                NREQ    = 4,
  parameter int                AWIDTH  = 8,
  parameter int                TIMEOUT = 16,
  parameter logic [AWIDTH-1:0] PAD     = AWIDTH'(PAD_DEFAULT)
) (
  input logic                  clk,
  input logic                  rst,
  width_change_arbiter_if.slave bus
);

  localparam int              SRCW     = src_width(NREQ);
  localparam int              CNTW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = (TIMEOUT > 0) ? CNTW'(TIMEOUT - 1) : '0;
  localparam logic [SRCW-1:0] SRC_LAST = SRCW'(NREQ - 1);

  state_e            state_q, state_d;
  logic [SRCW-1:0]   grant_q, grant_d;
  logic [SRCW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNTW-1:0]   wait_cnt_q, wait_cnt_d;
  logic              a_vld_q, a_vld_d;
  logic [AWIDTH-1:0] a_q, a_d;
  logic              pair_done_q, pair_done_d;
  logic              pair_pad_q, pair_pad_d;
  logic [SRCW-1:0]   pair_src_q, pair_src_d;

  logic [NREQ-1:0]   arb_req, win_oh, req_rdy;
  logic [SRCW-1:0]   win_idx, sel_idx, next_ptr;
  logic              win_vld, xfer, timeout_hit;
  logic [AWIDTH-1:0] sel_data;

  // A source that just timed out sits out the cycle in which its pad is issued.
  always_comb begin
    arb_req = bus.req_vld;
    if (pair_pad_q) arb_req[grant_q] = 1'b0;
  end

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req     (arb_req),
    .ptr     (rr_ptr_q),
    .gnt_oh  (win_oh),
    .gnt_idx (win_idx),
    .gnt_vld (win_vld)
  );

  always_comb begin
    req_rdy = '0;
    if (!rst) begin
      if (state_q == HI) req_rdy[grant_q] = 1'b1;
      else if (win_vld)  req_rdy = win_oh;
    end
  end

  assign xfer        = |(bus.req_vld & req_rdy);
  assign sel_idx     = (state_q == HI) ? grant_q : win_idx;
  assign sel_data    = bus.req_data[int'(sel_idx) * AWIDTH +: AWIDTH];
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == CNT_LAST);
  assign next_ptr    = (grant_q == SRC_LAST) ? '0 : grant_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      wait_cnt_q  <= '0;
      a_vld_q     <= 1'b0;
      a_q         <= '0;
      pair_done_q <= 1'b0;
      pair_pad_q  <= 1'b0;
      pair_src_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      wait_cnt_q  <= wait_cnt_d;
      a_vld_q     <= a_vld_d;
      a_q         <= a_d;
      pair_done_q <= pair_done_d;
      pair_pad_q  <= pair_pad_d;
      pair_src_q  <= pair_src_d;
    end
  end

  // The pointer only moves when a pair closes, so a busy source cannot take two pairs in a row.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d    = HI;
          grant_d    = win_idx;
          wait_cnt_d = '0;
        end
      end
      HI: begin
        if (xfer || timeout_hit) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end else if (wait_cnt_q != '1) begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_vld_d     = 1'b0;
    a_d         = a_q;
    pair_done_d = 1'b0;
    pair_pad_d  = 1'b0;
    pair_src_d  = pair_src_q;
    if (xfer) begin
      a_vld_d = 1'b1;
      a_d     = sel_data;
      if (state_q == HI) begin
        pair_done_d = 1'b1;
        pair_src_d  = grant_q;
      end
    end else if (state_q == HI && timeout_hit) begin
      a_vld_d     = 1'b1;
      a_d         = PAD;
      pair_done_d = 1'b1;
      pair_pad_d  = 1'b1;
      pair_src_d  = grant_q;
    end
  end

  assign bus.req_rdy   = req_rdy;
  assign bus.a_vld     = a_vld_q;
  assign bus.a         = a_q;
  assign bus.pair_done = pair_done_q;
  assign bus.pair_pad  = pair_pad_q;
  assign bus.pair_src  = pair_src_q;
  assign bus.busy      = (state_q == HI);

endmodule

// File: tb/tb_width_change_arbiter.sv
// Drives two arbiters (TIMEOUT 16 and 4) with the same byte streams and compares both
// against a pair-level reference model, plus directed expectations from the test plan.
module tb_width_change_arbiter;
  import width_change_pkg::*;

  localparam int NREQ   = 4;
  localparam int AWIDTH = 8;
  localparam int TO_A   = 16;
  localparam int TO_B   = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_vld;
  logic [NREQ*AWIDTH-1:0] req_data;

  always #5 clk = ~clk;

  width_change_arbiter_if #(.NREQ(NREQ), .AWIDTH(AWIDTH)) bus_a ();
  width_change_arbiter_if #(.NREQ(NREQ), .AWIDTH(AWIDTH)) bus_b ();

  assign bus_a.req_vld  = req_vld;
  assign bus_a.req_data = req_data;
  assign bus_b.req_vld  = req_vld;
  assign bus_b.req_data = req_data;

  width_change_arbiter #(.NREQ(NREQ), .AWIDTH(AWIDTH), .TIMEOUT(TO_A), .PAD(8'h00)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  width_change_arbiter #(.NREQ(NREQ), .AWIDTH(AWIDTH), .TIMEOUT(TO_B), .PAD(8'h00)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  logic [NREQ-1:0]   rdy_o[2];
  logic              a_vld_o[2], done_o[2], pad_o[2], busy_o[2];
  logic [AWIDTH-1:0] a_o[2];
  logic [1:0]        src_o[2];

  assign rdy_o[0] = bus_a.req_rdy;   assign rdy_o[1] = bus_b.req_rdy;
  assign a_vld_o[0] = bus_a.a_vld;   assign a_vld_o[1] = bus_b.a_vld;
  assign a_o[0] = bus_a.a;           assign a_o[1] = bus_b.a;
  assign done_o[0] = bus_a.pair_done; assign done_o[1] = bus_b.pair_done;
  assign pad_o[0] = bus_a.pair_pad;  assign pad_o[1] = bus_b.pair_pad;
  assign src_o[0] = bus_a.pair_src;  assign src_o[1] = bus_b.pair_src;
  assign busy_o[0] = bus_a.busy;     assign busy_o[1] = bus_b.busy;

  // Reference model: a pair in progress has an owner and a start cycle; nothing more.
  bit          hold[2];
  bit          blk[2];
  int          owner[2], start[2], ptr[2];
  int          timeout_of[2] = '{TO_A, TO_B};
  bit          e_vld[2], e_done[2], e_pad[2], e_busy[2], e_full[2];
  logic [7:0]  e_a[2];
  int          e_src[2];
  logic [3:0]  seen_rdy[2];
  int          cyc;
  int          n_checks;
  int          n_fail;

  bit          conv_phase;
  logic [7:0]  conv_lo;
  logic [15:0] conv_b;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_rdy(input int m);
    if (rst) return 4'b0000;
    if (hold[m]) return 4'(1 << owner[m]);
    for (int k = 0; k < NREQ; k++) begin
      int s;
      s = (ptr[m] + k) % NREQ;
      if (req_vld[s] && !(blk[m] && s == owner[m])) return 4'(1 << s);
    end
    return 4'b0000;
  endfunction

  task automatic model_step(input int m, input logic [3:0] rdy);
    bit         xfer;
    int         s;
    logic [7:0] byte_v;
    if (rst) begin
      hold[m] = 0; blk[m] = 0; ptr[m] = 0; owner[m] = 0;
      e_vld[m] = 0; e_done[m] = 0; e_pad[m] = 0; e_busy[m] = 0;
      e_a[m] = 8'h00; e_src[m] = 0; e_full[m] = 1;
      return;
    end
    e_full[m] = 0;
    xfer = |(req_vld & rdy);
    s = 0;
    for (int k = 0; k < NREQ; k++) if (rdy[k]) s = k;
    byte_v = req_data[s*AWIDTH +: AWIDTH];
    e_vld[m] = 0; e_done[m] = 0; e_pad[m] = 0; blk[m] = 0;
    if (!hold[m]) begin
      if (xfer) begin
        hold[m] = 1; owner[m] = s; start[m] = cyc;
        e_vld[m] = 1; e_a[m] = byte_v;
      end
    end else if (xfer) begin
      e_vld[m] = 1; e_a[m] = byte_v; e_done[m] = 1; e_src[m] = owner[m];
      hold[m] = 0; ptr[m] = (owner[m] + 1) % NREQ;
    end else if (timeout_of[m] != 0 && cyc - start[m] == timeout_of[m]) begin
      e_vld[m] = 1; e_a[m] = 8'h00; e_done[m] = 1; e_pad[m] = 1; e_src[m] = owner[m];
      hold[m] = 0; ptr[m] = (owner[m] + 1) % NREQ; blk[m] = 1;
    end
    e_busy[m] = hold[m];
  endtask

  // One clock: ready checked mid-cycle, registered outputs checked just after the edge.
  task automatic apply_cycle();
    logic [3:0] r;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      r = model_rdy(m);
      seen_rdy[m] = rdy_o[m];
      check_output($sformatf("dut%0d.req_rdy", m), 32'(rdy_o[m]), 32'(r));
      model_step(m, r);
    end
    if (rst) conv_phase = 0;
    else if (a_vld_o[0]) begin
      if (!conv_phase) begin conv_lo = a_o[0]; conv_phase = 1; end
      else begin conv_b = {a_o[0], conv_lo}; conv_phase = 0; end
    end
    cyc++;
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      check_output($sformatf("dut%0d.a_vld", m), 32'(a_vld_o[m]), 32'(e_vld[m]));
      check_output($sformatf("dut%0d.pair_done", m), 32'(done_o[m]), 32'(e_done[m]));
      check_output($sformatf("dut%0d.pair_pad", m), 32'(pad_o[m]), 32'(e_pad[m]));
      check_output($sformatf("dut%0d.busy", m), 32'(busy_o[m]), 32'(e_busy[m]));
      if (e_vld[m] || e_full[m])
        check_output($sformatf("dut%0d.a", m), 32'(a_o[m]), 32'(e_a[m]));
      if (e_done[m] || e_full[m])
        check_output($sformatf("dut%0d.pair_src", m), 32'(src_o[m]), 32'(e_src[m]));
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_vld = '0;
    apply_cycle();
    rst = 1'b0;
  endtask

  task automatic set_byte(input int i, input logic [7:0] v);
    req_data[i*AWIDTH +: AWIDTH] = v;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    conv_phase = 0; conv_lo = '0; conv_b = '0;
    rst = 1'b1; req_vld = '0; req_data = '0;
    apply_cycle();
    apply_reset();
    check_output("reset.a", 32'(a_o[0]), 32'h0);
    check_output("reset.busy", 32'(busy_o[0]), 32'h0);

    // Two sources, continuous valid: 11,22 from src0 then 33,44 from src2.
    req_vld = 4'b0101; set_byte(0, 8'h11); set_byte(2, 8'h33);
    apply_cycle();
    check_output("t1.a0", 32'(a_o[0]), 32'h11);
    check_output("t1.done0", 32'(done_o[0]), 32'h0);
    set_byte(0, 8'h22);
    apply_cycle();
    check_output("t1.a1", 32'(a_o[0]), 32'h22);
    check_output("t1.done1", 32'(done_o[0]), 32'h1);
    check_output("t1.src1", 32'(src_o[0]), 32'h0);
    apply_cycle();
    check_output("t1.a2", 32'(a_o[0]), 32'h33);
    check_output("t1.done2", 32'(done_o[0]), 32'h0);
    set_byte(2, 8'h44);
    apply_cycle();
    check_output("t1.a3", 32'(a_o[0]), 32'h44);
    check_output("t1.done3", 32'(done_o[0]), 32'h1);
    check_output("t1.src3", 32'(src_o[0]), 32'h2);
    req_vld = '0;

    // All four sources valid: eight back-to-back pairs in strict rotation.
    apply_reset();
    req_vld = 4'b1111;
    for (int p = 0; p < 8; p++) begin
      for (int h = 0; h < 2; h++) begin
        req_data = $urandom;
        apply_cycle();
        if (h == 1) begin
          check_output("t2.done", 32'(done_o[0]), 32'h1);
          check_output("t2.src", 32'(src_o[0]), 32'(p % NREQ));
        end
      end
    end
    req_vld = '0;

    // src1 stalls 5 cycles mid-pair under TIMEOUT=16, then completes with BB.
    apply_reset();
    req_vld = 4'b0010; set_byte(1, 8'hAA);
    apply_cycle();
    check_output("t3.first", 32'(a_o[0]), 32'hAA);
    req_vld = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      req_data = $urandom;
      apply_cycle();
      check_output("t3.rdy", 32'(seen_rdy[0]), 32'h2);
      check_output("t3.busy", 32'(busy_o[0]), 32'h1);
    end
    req_vld = 4'b1111; set_byte(1, 8'hBB);
    apply_cycle();
    check_output("t3.a", 32'(a_o[0]), 32'hBB);
    check_output("t3.done", 32'(done_o[0]), 32'h1);
    check_output("t3.pad", 32'(pad_o[0]), 32'h0);
    req_vld = '0;

    // src3 goes silent under TIMEOUT=4: pad exactly four cycles after the first byte.
    apply_reset();
    req_vld = 4'b1000; set_byte(3, 8'h5A);
    apply_cycle();
    check_output("t4.first", 32'(a_o[1]), 32'h5A);
    req_vld = '0;
    for (int i = 0; i < 3; i++) begin
      apply_cycle();
      check_output("t4.gap", 32'(a_vld_o[1]), 32'h0);
    end
    apply_cycle();
    check_output("t4.a", 32'(a_o[1]), 32'h00);
    check_output("t4.vld", 32'(a_vld_o[1]), 32'h1);
    check_output("t4.pad", 32'(pad_o[1]), 32'h1);
    check_output("t4.src", 32'(src_o[1]), 32'h3);
    apply_cycle();
    check_output("t4.idle", 32'(busy_o[1]), 32'h0);

    // Second byte lands on the timeout cycle itself: real byte wins.
    apply_reset();
    req_vld = 4'b1000; set_byte(3, 8'h5A);
    apply_cycle();
    req_vld = '0;
    for (int i = 0; i < 3; i++) apply_cycle();
    req_vld = 4'b1000; set_byte(3, 8'hC3);
    apply_cycle();
    check_output("t5.a", 32'(a_o[1]), 32'hC3);
    check_output("t5.done", 32'(done_o[1]), 32'h1);
    check_output("t5.pad", 32'(pad_o[1]), 32'h0);
    req_vld = '0;

    // Reset right after a first byte: half-pair dropped, converter realigns.
    apply_reset();
    req_vld = 4'b0001; set_byte(0, 8'h11);
    apply_cycle();
    rst = 1'b1; set_byte(0, 8'h22);
    apply_cycle();
    check_output("t6.vld", 32'(a_vld_o[0]), 32'h0);
    check_output("t6.done", 32'(done_o[0]), 32'h0);
    check_output("t6.busy", 32'(busy_o[0]), 32'h0);
    rst = 1'b0; set_byte(0, 8'h11);
    apply_cycle();
    set_byte(0, 8'h22);
    apply_cycle();
    check_output("t6.src", 32'(src_o[0]), 32'h0);
    req_vld = '0;
    apply_cycle();
    check_output("t6.conv_b", 32'(conv_b), 32'h2211);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      req_vld = 4'($urandom);
      req_data = $urandom;
      apply_cycle();
    end
    rst = 1'b0; req_vld = '0;
    apply_cycle();
    apply_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
